// File: rtl/opl3_channel_mixer_if.sv
// Operator-slot bus into the OPL3 channel mixer and the stereo sample bus out of it.
// The master drives the slot stream; the slave is the mixer.
interface opl3_channel_mixer_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int OP_OUT_WIDTH = 13
);
  logic                           sample_clk_en;
  logic                           op_valid;
  logic signed [OP_OUT_WIDTH-1:0] op_out;
  logic                           op_is_carrier;
  logic                           cha;
  logic                           chb;
  logic                           overrun_clr;
  logic signed [SAMPLE_WIDTH-1:0] sample_l;
  logic signed [SAMPLE_WIDTH-1:0] sample_r;
  logic                           sample_valid;
  logic                           overrun;

  modport master (
    output sample_clk_en, op_valid, op_out, op_is_carrier, cha, chb, overrun_clr,
    input  sample_l, sample_r, sample_valid, overrun
  );

  modport slave (
    input  sample_clk_en, op_valid, op_out, op_is_carrier, cha, chb, overrun_clr,
    output sample_l, sample_r, sample_valid, overrun
  );
endinterface

// File: rtl/opl3_channel_mixer.sv
// Sums carrier operator outputs of one sample frame into left/right accumulators and emits a stereo sample.
// Define OPL3_MIX_SATURATE_EN to clamp the accumulator into the sample range; otherwise it wraps.
module opl3_channel_mixer #(
  parameter int NUM_SLOTS    = 36,
  parameter int ACC_WIDTH    = 19,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  opl3_channel_mixer_if.slave    bus
);
  localparam int OP_OUT_WIDTH = 13;
  localparam int SLOT_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS + 1) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
  localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'((1 << (SAMPLE_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                         state_q, state_d;
  logic signed [ACC_WIDTH-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic        [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
  logic signed [SAMPLE_WIDTH-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic                           sample_valid_q, sample_valid_d;
  logic                           overrun_q, overrun_d;
  logic                           overrun_set;
  logic signed [ACC_WIDTH-1:0]    op_ext;

  function automatic logic signed [SAMPLE_WIDTH-1:0] to_sample(input logic signed [ACC_WIDTH-1:0] a);
`ifdef OPL3_MIX_SATURATE_EN
    if (a > SMAX)      return SMAX[SAMPLE_WIDTH-1:0];
    else if (a < SMIN) return SMIN[SAMPLE_WIDTH-1:0];
    else               return a[SAMPLE_WIDTH-1:0];
`else
    return a[SAMPLE_WIDTH-1:0];
`endif
  endfunction

  assign op_ext = {{(ACC_WIDTH - OP_OUT_WIDTH){bus.op_out[OP_OUT_WIDTH-1]}}, bus.op_out};

  always_comb begin
    state_d        = state_q;
    acc_l_d        = acc_l_q;
    acc_r_d        = acc_r_q;
    slot_cnt_d     = slot_cnt_q;
    sample_l_d     = sample_l_q;
    sample_r_d     = sample_r_q;
    sample_valid_d = 1'b0;
    overrun_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.sample_clk_en) begin
          acc_l_d    = '0;
          acc_r_d    = '0;
          slot_cnt_d = '0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        // A frame strobe mid-frame restarts the frame and drops any slot presented with it.
        if (bus.sample_clk_en) begin
          acc_l_d     = '0;
          acc_r_d     = '0;
          slot_cnt_d  = '0;
          overrun_set = 1'b1;
        end else if (bus.op_valid) begin
          if (bus.op_is_carrier && bus.cha) acc_l_d = acc_l_q + op_ext;
          if (bus.op_is_carrier && bus.chb) acc_r_d = acc_r_q + op_ext;
          slot_cnt_d = slot_cnt_q + SLOT_W'(1);
          if (slot_cnt_q == LAST_SLOT) state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        sample_l_d     = to_sample(acc_l_q);
        sample_r_d     = to_sample(acc_r_q);
        sample_valid_d = 1'b1;
        if (bus.sample_clk_en) begin
          acc_l_d    = '0;
          acc_r_d    = '0;
          slot_cnt_d = '0;
          state_d    = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (overrun_set)          overrun_d = 1'b1;
    else if (bus.overrun_clr) overrun_d = 1'b0;
    else                      overrun_d = overrun_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      acc_l_q        <= '0;
      acc_r_q        <= '0;
      slot_cnt_q     <= '0;
      sample_l_q     <= '0;
      sample_r_q     <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_l_q        <= acc_l_d;
      acc_r_q        <= acc_r_d;
      slot_cnt_q     <= slot_cnt_d;
      sample_l_q     <= sample_l_d;
      sample_r_q     <= sample_r_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.sample_l     = sample_l_q;
  assign bus.sample_r     = sample_r_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.overrun      = overrun_q;
endmodule
